// File: rtl/cache_instruction_arbiter_pkg.sv
// Shared types for the cache instruction arbiter: the load/store
// instruction bundle, address widths and hazard helper functions.
package cache_instruction_arbiter_pkg;

  localparam int CACHE_ADDR_W  = 13;
  localparam int REGFILE_REG_W = 2;

  typedef struct packed {
    logic                     valid;
    logic                     is_load;
    logic [1:0]               cache_slot;
    logic [10:0]              cache_addr;
    logic [REGFILE_REG_W-1:0] regfile_reg;
  } regfile_instruction;

  // Does a new request conflict with one in-flight instruction?
  function automatic logic conflicts(
    regfile_instruction req,
    regfile_instruction old
  );
    logic [CACHE_ADDR_W-1:0] ra;
    logic [CACHE_ADDR_W-1:0] oa;
    ra = {req.cache_slot, req.cache_addr};
    oa = {old.cache_slot, old.cache_addr};
    if (!old.valid) return 1'b0;
    if (!req.is_load)
      return old.is_load &&
             (old.regfile_reg == req.regfile_reg);
    return !old.is_load && (ra == oa);
  endfunction

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cache_instruction_arbiter_rr.sv
// Round-robin picker: first eligible index at or after ptr, wrapping.
// Ports: eligible, ptr in; grant (one-hot), grant_idx, grant_any out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_instruction_arbiter.sv
// Issues one thread load/store per cycle to the cache pipeline,
// round-robin, holding back requests with regfile or cache RAW hazards.
// Ports: clk/reset; req_valid/req_instr/req_ready per requester;
// issue_en; issue_instr/issue_id; hazard_stall; issued/stall counters.
module cache_instruction_arbiter
  import cache_instruction_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int HIST_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  regfile_instruction [NUM_REQ-1:0]   req_instr,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic                               issue_en,
  output regfile_instruction                 issue_instr,
  output logic [$clog2(NUM_REQ)-1:0]         issue_id,
  output logic                               hazard_stall,
  output logic [15:0]                        issued_count,
  output logic [15:0]                        stall_count
);

  localparam int IW = $clog2(NUM_REQ);

  regfile_instruction issue_instr_q, issue_instr_d;
  regfile_instruction hist_q [HIST_DEPTH];
  regfile_instruction hist_d [HIST_DEPTH];
  logic [IW-1:0]      issue_id_q, issue_id_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               hazard_stall_q, hazard_stall_d;
  logic [15:0]        issued_count_q, issued_count_d;
  logic [15:0]        stall_count_q, stall_count_d;

  logic [NUM_REQ-1:0] haz;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;

  // hist[0] is loaded alongside issue_instr, so the hazard window
  // covers the HIST_DEPTH cycles following a grant.
  always_comb begin
    haz      = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (conflicts(req_instr[i], issue_instr_q)) haz[i] = 1'b1;
      for (int h = 0; h < HIST_DEPTH; h++)
        if (conflicts(req_instr[i], hist_q[h])) haz[i] = 1'b1;
      eligible[i] = req_valid[i] & issue_en & ~reset & ~haz[i];
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .eligible  (eligible),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    issue_instr_d       = issue_instr_q;
    issue_instr_d.valid = 1'b0;
    issue_id_d          = issue_id_q;
    rr_ptr_d            = rr_ptr_q;
    issued_count_d      = issued_count_q;
    stall_count_d       = stall_count_q;
    hazard_stall_d      = |(req_valid & haz);
    if (grant_any) begin
      issue_instr_d       = req_instr[grant_idx];
      issue_instr_d.valid = 1'b1;
      issue_id_d          = grant_idx;
      rr_ptr_d            = (grant_idx == IW'(NUM_REQ - 1)) ?
                            '0 : grant_idx + 1'b1;
      issued_count_d      = sat_inc(issued_count_q);
    end else if (|req_valid) begin
      stall_count_d = sat_inc(stall_count_q);
    end
    hist_d[0] = issue_instr_d;
    for (int h = 1; h < HIST_DEPTH; h++) hist_d[h] = hist_q[h-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_instr_q  <= '0;
      issue_id_q     <= '0;
      rr_ptr_q       <= '0;
      hazard_stall_q <= 1'b0;
      issued_count_q <= '0;
      stall_count_q  <= '0;
      for (int h = 0; h < HIST_DEPTH; h++) hist_q[h] <= '0;
    end else begin
      issue_instr_q  <= issue_instr_d;
      issue_id_q     <= issue_id_d;
      rr_ptr_q       <= rr_ptr_d;
      hazard_stall_q <= hazard_stall_d;
      issued_count_q <= issued_count_d;
      stall_count_q  <= stall_count_d;
      for (int h = 0; h < HIST_DEPTH; h++) hist_q[h] <= hist_d[h];
    end
  end

  assign req_ready    = grant;
  assign issue_instr  = issue_instr_q;
  assign issue_id     = issue_id_q;
  assign hazard_stall = hazard_stall_q;
  assign issued_count = issued_count_q;
  assign stall_count  = stall_count_q;

endmodule

// File: doc/cache_instruction_arbiter.md
CACHE_INSTRUCTION_ARBITER -- requirements
Module: cache_instruction_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (thread issue ports), range 2..8.
REQ-002 SHALL have parameter HIST_DEPTH, default 2, number of in-flight pipeline stages tracked for hazards.
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 Ports, in this order (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  sync active-high reset.
- req_valid  in  NUM_REQ  per-requester instruction valid.
- req_instr  in  NUM_REQ x regfile_instruction  per-requester load/store instruction.
- req_ready  out  NUM_REQ  per-requester accept; transfer when valid and ready are both high.
- issue_en  in  1  downstream pipeline accepting; 0 pauses all grants.
- issue_instr  out  regfile_instruction  registered instruction driven to the load/store pipeline.
- issue_id  out  $clog2(NUM_REQ)  requester index of issue_instr.
- hazard_stall  out  1  registered; at least one valid requester was blocked by a hazard last cycle.
- issued_count  out  16  total instructions issued.
- stall_count  out  16  cycles with any valid requester but no grant.

Function
REQ-005 SHALL grant at most one requester per cycle; req_ready is combinational and one-hot or zero.
REQ-006 Eligible requester: req_valid high, issue_en high, and no hazard (REQ-008/009).
REQ-007 SHALL pick the eligible requester by round-robin: search starts at rr_ptr and wraps modulo NUM_REQ; after a grant to i, rr_ptr becomes (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
REQ-008 Regfile RAW hazard: a store (is_load=0) SHALL be ineligible if any valid history entry is a load with the same regfile_reg.
REQ-009 Cache RAW hazard: a load SHALL be ineligible if any valid history entry is a store with the same {cache_slot, cache_addr}.
REQ-010 Hazard-blocked requesters SHALL NOT block lower-priority eligible requesters.
REQ-011 The cycle after a grant, issue_instr SHALL equal the granted req_instr with valid=1 and issue_id its index; otherwise issue_instr.valid=0 and the other fields hold.
REQ-012 Latency: request accepted in cycle t appears on issue_instr in cycle t+1.
REQ-013 History: HIST_DEPTH-entry shift register; each cycle, entry 0 loads issue_instr, including valid=0 bubbles, so entries age out after HIST_DEPTH cycles.
REQ-014 Hazard comparison SHALL also include the instruction currently on issue_instr.
REQ-015 issued_count SHALL increment on each grant; stall_count SHALL increment when any req_valid is high and no grant occurs. Both saturate at 16'hFFFF.
REQ-016 With issue_en low, req_ready=0 and issue_instr.valid=0 the next cycle; history keeps shifting bubbles.

Reset
REQ-017 On reset, the following SHALL be zero: issue_instr (all fields, valid=0), issue_id, hazard_stall, both counters, rr_ptr, and all history valid bits.
REQ-018 req_ready SHALL be 0 while reset is high; an instruction presented during reset is not accepted.
REQ-019 Reset during a pending hazard SHALL clear it; the first cycle after reset deassertion grants purely by round-robin from requester 0.

Structure
REQ-020 The regfile_instruction typedef (valid, is_load, cache_slot[1:0], cache_addr[10:0], regfile_reg[1:0]) SHALL live in the shared package, together with the CACHE_ADDR_W=13 and REGFILE_REG_W=2 constants.
REQ-021 Round-robin selection SHALL be a sub-module rr_arbiter (parameter N; inputs eligible and ptr; outputs grant one-hot, grant_idx, grant_any).

Verification
REQ-022 All four requesters hold valid, non-conflicting loads for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, one per cycle; issued_count=8.
REQ-023 Req0 load reg 2 granted at t; req1 store reg 2 valid from t+1 -> req1 blocked at t+1 and t+2, hazard_stall=1, req1 granted at t+3.
REQ-024 Req2 store slot 1 addr 0x005 granted; req3 load of the same address waits 2 cycles, while req0 load addr 0x006, valid at the same time, is granted immediately.
REQ-025 issue_en held low for 3 cycles with req1 valid -> no req_ready, no issue; stall_count += 3; req1 issues the cycle after issue_en rises.
REQ-026 Reset asserted the cycle after a grant -> issue_instr.valid=0, counters 0; the next grant goes to the lowest valid index.
REQ-027 Counter saturation: force 70000 grants -> issued_count reads 16'hFFFF and stays there.
